sng_stream_ctrl: RTL
====================

Name: sng_stream_ctrl

Overview:
Sequencer for one 8-bit LFSR stochastic number generator (SNG). On a start request it loads a seed into the SNG and runs it for a programmable number of cycles. Each cycle it compares the SNG output against a binary operand to emit one stochastic bit, and it counts the ones. It sits between the host/test logic and the SNG instance and owns the SNG's seed, enable and reset pins.

Parameters:
WIDTH, 8, SNG / operand / seed width in bits
LEN_W, 9, width of stream-length and ones-count fields (max length 2^(LEN_W-1) = 256)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a new stream; sampled only in IDLE
seed_in  input  WIDTH  SNG seed for this stream
value_in  input  WIDTH  binary operand to encode
length_in  input  LEN_W  number of stream bits to produce (0..256)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, stream finished
bit_out  output  1  stochastic bit, valid when bit_valid=1
bit_valid  output  1  high in every RUN cycle
ones_count  output  LEN_W  number of 1s emitted in current/last stream
sng_seed  output  WIDTH  to SNG seed
sng_reset  output  1  to SNG reset (SNG loads seed on a clock edge with reset high)
sng_enable  output  1  to SNG enable (SNG steps one LFSR state per enabled edge)
sng_data  input  WIDTH  SNG current LFSR state

Behaviour:
- Clock is clk; reset is synchronous and active-high, named reset.
- SNG contract: maximal-length LFSR (period 255 over nonzero states); sng_data equals the seed in the cycle after a load.
- Reset values: state=IDLE, busy=0, done=0, bit_valid=0, ones_count=0, sng_enable=0, seed register=8'h01. sng_reset = reset OR (state==LOAD), so the SNG is held in reset while the block is in reset.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - On start=1, latch seed_in, value_in and length_in, clear ones_count, go to LOAD.
  - seed_in==0 is replaced by 8'h01 (lock-up guard).
- LOAD: exactly 1 cycle; sng_reset=1, sng_enable=0.
  - If latched length==0, go to DONE.
  - Otherwise load remaining=length and go to RUN.
- RUN:
  - sng_enable=1 and bit_valid=1.
  - bit_out = (sng_data < value_reg), unsigned, combinational.
  - At the clock edge, ones_count += bit_out and remaining -= 1.
  - When remaining==1 at the edge, go to DONE. RUN therefore lasts exactly L cycles.
- DONE: exactly 1 cycle; done=1, sng_enable=0. Then go to IDLE.
- ones_count holds its final value until the next accepted start.
- Latency: start accepted in cycle t; first valid bit in cycle t+2; done in cycle t+2+L.
- start while busy is ignored; there is no queueing.
- Operand inputs (seed_in, value_in, length_in) may change freely after acceptance without effect.
- Reset asserted mid-stream: next cycle IDLE, ones_count=0, done is not pulsed.
- bit_out is 0 whenever bit_valid=0.
- value_in=0 gives all-zero bits. ones_count never overflows, because count <= length <= 256 fits in 9 bits.

Test Plan:
- Reset with start=1 held → IDLE, busy=0, done=0, ones_count=0, sng_reset=1 during reset. After release, first start accepted normally.
- seed=8'h21, value=8'd128, length=255 → 255 bit_valid cycles beginning 2 cycles after start, done pulse at start+257, ones_count=127. Repeat with value=0 → 0; with value=255 → 254.
- seed=8'h21, value=8'd128, length=256 → ones_count=128, since the seed state is revisited once and 0x21 < 128.
- length=0 → LOAD then DONE, zero bit_valid cycles, done at start+2, ones_count=0, sng_enable never high.
- seed_in=0, value=128, length=255 → sng_seed=8'h01, ones_count=127, no lock-up.
- start pulsed mid-RUN is ignored and ones_count is unaffected. Reset asserted at RUN cycle 10 → IDLE next cycle, no done, ones_count=0. A back-to-back start on the cycle after done is accepted.

Source files
------------

// File: rtl/sng_stream_ctrl.sv
// Sequencer for one LFSR stochastic number generator: seeds the SNG, runs it for
// a programmed number of cycles, compares each SNG state against a binary
// operand to emit one stochastic bit per cycle, and counts the emitted ones.
// Ports: clk/reset (sync, active-high); start/seed_in/value_in/length_in request
// a stream; busy/done/bit_out/bit_valid/ones_count report it; sng_seed,
// sng_reset, sng_enable drive the SNG and sng_data returns its current state.
module sng_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [WIDTH-1:0] value_in,
  input  logic [LEN_W-1:0] length_in,
  output logic             busy,
  output logic             done,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [LEN_W-1:0] ones_count,
  output logic [WIDTH-1:0] sng_seed,
  output logic             sng_reset,
  output logic             sng_enable,
  input  logic [WIDTH-1:0] sng_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] value_reg;
  logic [LEN_W-1:0] length_reg;
  logic [LEN_W-1:0] remaining;

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      seed_reg   <= WIDTH'(1);
      value_reg  <= '0;
      length_reg <= '0;
      remaining  <= '0;
      ones_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            // An all-zero seed would lock the LFSR; substitute state 1.
            seed_reg   <= (seed_in == '0) ? WIDTH'(1) : seed_in;
            value_reg  <= value_in;
            length_reg <= length_in;
            ones_count <= '0;
          end
        end
        LOAD: begin
          remaining <= length_reg;
        end
        RUN: begin
          ones_count <= ones_count + LEN_W'(bit_out);
          remaining  <= remaining - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_nxt  = state;
    done       = 1'b0;
    bit_valid  = 1'b0;
    bit_out    = 1'b0;
    sng_enable = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        // The SNG captures the seed at the end of this cycle, so the first
        // RUN cycle already sees the seed on sng_data.
        state_nxt = (length_reg == '0) ? DONE : RUN;
      end
      RUN: begin
        sng_enable = 1'b1;
        bit_valid  = 1'b1;
        bit_out    = (sng_data < value_reg);
        if (remaining == LEN_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign sng_seed  = seed_reg;
  // Hold the SNG in reset while this block is in reset, and load it in LOAD.
  assign sng_reset = reset | (state == LOAD);

endmodule
